// File: rtl/fifo_module_pkg.sv
// Shared constants for the byte FIFO: default word width and storage depth.
package fifo_module_pkg;
    localparam int FIFO_DATA_W = 8;
    localparam int FIFO_DEPTH  = 16;
endpackage

// File: rtl/fifo_module_if.sv
// Producer/consumer handshake bundle for the byte FIFO.
interface fifo_module_if
    import fifo_module_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W
) ();
    logic              write_req;
    logic [DATA_W-1:0] FIFO_write_data;
    logic              read_req;
    logic [DATA_W-1:0] FIFO_read_data;
    logic              full_sig;
    logic              empty_sig;

    modport master (
        output write_req, FIFO_write_data, read_req,
        input  FIFO_read_data, full_sig, empty_sig
    );

    modport slave (
        input  write_req, FIFO_write_data, read_req,
        output FIFO_read_data, full_sig, empty_sig
    );
endinterface

// File: rtl/fifo_module_ram.sv
// Simple dual-port storage: one write port, one registered read port, no reset.
module fifo_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Read register only loads on a pop, so the last popped word is held.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/fifo_module.sv
// Single-clock byte FIFO: pointers, occupancy count and flags around fifo_ram.
module fifo_module
    import fifo_module_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int DEPTH  = FIFO_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    fifo_module_if.slave bus
);
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("fifo_module: DEPTH must be a power of two and at least 2");
    end

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              loaded_q, loaded_d;
    logic              wr_ok, rd_ok;
    logic [DATA_W-1:0] ram_rdata;

    assign bus.empty_sig = (count_q == '0);
    assign bus.full_sig  = (count_q == FULL_COUNT);
    assign wr_ok = bus.write_req & ~bus.full_sig;
    assign rd_ok = bus.read_req  & ~bus.empty_sig;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        loaded_d = loaded_q | rd_ok;
        if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            loaded_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            loaded_q <= loaded_d;
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr_q),
        .wdata (bus.FIFO_write_data),
        .re    (rd_ok),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    // The RAM read register has no reset; mask it until the first pop after reset.
    assign bus.FIFO_read_data = loaded_q ? ram_rdata : '0;
endmodule

// File: tb/tb_fifo_module.sv
// Directed bench for fifo_module: reset, mixed traffic, fill/drain, wrap and async reset.
module tb_fifo_module;
    import fifo_module_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    fifo_module_if #(.DATA_W(FIFO_DATA_W)) bus ();

    fifo_module dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One clock of stimulus; returns 2 ns after the rising edge with inputs idle.
    task automatic step(input logic w, input logic [7:0] d, input logic r);
        bus.write_req       = w;
        bus.FIFO_write_data = d;
        bus.read_req        = r;
        @(posedge clk);
        #2;
        bus.write_req = 1'b0;
        bus.read_req  = 1'b0;
        $display("txn t=%0t wr=%0b d=%0d rd=%0b -> q=%0d empty=%0b full=%0b",
                 $time, w, d, r, bus.FIFO_read_data, bus.empty_sig, bus.full_sig);
    endtask

    task automatic check_flags(input string tag, input logic e, input logic f);
        check({tag, "_empty"}, 8'(bus.empty_sig), 8'(e));
        check({tag, "_full"},  8'(bus.full_sig),  8'(f));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        bus.write_req       = 1'b0;
        bus.read_req        = 1'b0;
        bus.FIFO_write_data = 8'd0;

        // Reset
        rst_n = 1'b0;
        #250;
        check_flags("rst", 1'b1, 1'b0);
        check("rst_q", bus.FIFO_read_data, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Write 5, idle, write 6 + read, read
        step(1'b1, 8'd5, 1'b0);
        check_flags("w5", 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b0);
        step(1'b1, 8'd6, 1'b1);
        check("wr6rd_q", bus.FIFO_read_data, 8'd5);
        check_flags("wr6rd", 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b1);
        check("rd6_q", bus.FIFO_read_data, 8'd6);
        check_flags("rd6", 1'b1, 1'b0);

        // 100, 33+read, read, 99+read (read gated by empty), read
        step(1'b1, 8'd100, 1'b0);
        step(1'b1, 8'd33, 1'b1);
        check("seq_q100", bus.FIFO_read_data, 8'd100);
        step(1'b0, 8'd0, 1'b1);
        check("seq_q33", bus.FIFO_read_data, 8'd33);
        check_flags("seq_e", 1'b1, 1'b0);
        step(1'b1, 8'd99, 1'b1);
        check("seq_hold33", bus.FIFO_read_data, 8'd33);
        check_flags("seq_w99", 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b1);
        check("seq_q99", bus.FIFO_read_data, 8'd99);
        check_flags("seq_end", 1'b1, 1'b0);

        // Fill: 20 write attempts, only the first 16 land
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'(10 + i), 1'b0);
            check("fill_full", 8'(bus.full_sig), 8'(i >= 15));
        end
        check("fill_empty", 8'(bus.empty_sig), 8'd0);
        check("fill_hold", bus.FIFO_read_data, 8'd99);

        // Drain: 16 words in order, then one blocked extra read
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'd0, 1'b1);
            check("drain_q", bus.FIFO_read_data, 8'(10 + i));
            check("drain_empty", 8'(bus.empty_sig), 8'(i == 15));
        end
        step(1'b0, 8'd0, 1'b1);
        check("drain_hold", bus.FIFO_read_data, 8'd25);
        check_flags("drain_extra", 1'b1, 1'b0);

        // Wrap: fill 10 / drain 10, fill 16 / drain 16
        for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 8'd0, 1'b1);
            check("wrap10_q", bus.FIFO_read_data, 8'(8'h40 + i));
        end
        check_flags("wrap10_end", 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
        check_flags("wrap16_full", 1'b0, 1'b1);
        step(1'b1, 8'hEE, 1'b1);
        check("wrap_fullrw_q", bus.FIFO_read_data, 8'h80);
        check_flags("wrap_fullrw", 1'b0, 1'b0);
        for (int i = 1; i < 16; i++) begin
            step(1'b0, 8'd0, 1'b1);
            check("wrap16_q", bus.FIFO_read_data, 8'(8'h80 + i));
        end
        check_flags("wrap16_end", 1'b1, 1'b0);

        // Async reset mid-stream
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b1);
        check("prerst_q", bus.FIFO_read_data, 8'h11);
        #1;
        rst_n = 1'b0;
        #1;
        check_flags("async_rst", 1'b1, 1'b0);
        check("async_rst_q", bus.FIFO_read_data, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 8'd0, 1'b1);
        check("postrst_blocked_q", bus.FIFO_read_data, 8'd0);
        check_flags("postrst", 1'b1, 1'b0);
        step(1'b1, 8'h55, 1'b0);
        step(1'b0, 8'd0, 1'b1);
        check("postrst_q", bus.FIFO_read_data, 8'h55);
        check_flags("postrst_end", 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
